// File: rtl/ser_deser.sv
// LSB-first serial-to-parallel collector with a valid/ready word output.
// Optional SER_DESER_SEXT_EN: byte/half/word lengths with optional sign extension (WIDTH must be 32).
module ser_deser #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_d,
    input  logic [1:0]       i_len,
    input  logic             i_signed,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_q,
    output logic [1:0]       o_state
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: a word transfers on any rising edge where o_valid=1 and i_ready=1;
    // o_q is stable from the rise of o_valid until that edge.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              busy_q, valid_q;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  word;
    logic [CW-1:0]     last_idx;
    logic              unused_bits;

`ifdef SER_DESER_SEXT_EN
    logic [1:0] len_q, len_d;
    logic       sgn_q, sgn_d;

    // The shift register is effectively N bits wide: new bits enter at sr[N-1].
    always_comb begin
        shifted  = {i_d, sr_q[WIDTH-1:1]};
        word     = shifted;
        last_idx = CW'(WIDTH - 1);
        case (len_q)
            2'd0: begin
                shifted  = {{(WIDTH-8){1'b0}}, i_d, sr_q[7:1]};
                word     = {{(WIDTH-8){sgn_q & i_d}}, i_d, sr_q[7:1]};
                last_idx = CW'(7);
            end
            2'd1: begin
                shifted  = {{(WIDTH-16){1'b0}}, i_d, sr_q[15:1]};
                word     = {{(WIDTH-16){sgn_q & i_d}}, i_d, sr_q[15:1]};
                last_idx = CW'(15);
            end
            default: ;
        endcase
    end
    assign unused_bits = sr_q[0];
`else
    always_comb begin
        shifted  = {i_d, sr_q[WIDTH-1:1]};
        word     = shifted;
        last_idx = CW'(WIDTH - 1);
    end
    assign unused_bits = ^{sr_q[0], i_len, i_signed};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = q_q;
`ifdef SER_DESER_SEXT_EN
        len_d   = len_q;
        sgn_d   = sgn_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    sr_d    = '0;
                    q_d     = '0;
`ifdef SER_DESER_SEXT_EN
                    len_d   = i_len;
                    sgn_d   = i_signed;
`endif
                end
            end
            S_COLLECT: begin
                if (i_en) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == last_idx) begin
                        state_d = S_HOLD;
                        q_d     = word;
                    end
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    // Back-to-back restart skips the IDLE bubble.
                    if (i_start) begin
                        state_d = S_COLLECT;
                        cnt_d   = '0;
                        sr_d    = '0;
                        q_d     = '0;
`ifdef SER_DESER_SEXT_EN
                        len_d   = i_len;
                        sgn_d   = i_signed;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SER_DESER_SEXT_EN
            len_q   <= 2'd2;
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            busy_q  <= (state_d == S_COLLECT);
            valid_q <= (state_d == S_HOLD);
`ifdef SER_DESER_SEXT_EN
            len_q   <= len_d;
            sgn_q   <= sgn_d;
`endif
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_q     = q_q;
    assign o_state = state_q;
endmodule

// File: tb/tb_ser_deser.sv
// Self-checking bench for ser_deser: directed words, expected-word queue, handshake monitor.
module tb_ser_deser;
    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic         i_en;
    logic         i_d;
    logic [1:0]   i_len;
    logic         i_signed;
    logic         o_busy;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_q;
    logic [1:0]   o_state;

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    ser_deser #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_en    (i_en),
        .i_d     (i_d),
        .i_len   (i_len),
        .i_signed(i_signed),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_q     (o_q),
        .o_state (o_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_word(input logic [1:0] len, input logic sgn);
        i_start  = 1'b1;
        i_len    = len;
        i_signed = sgn;
        tick();
        i_start  = 1'b0;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input bit gapped);
        for (int i = lo; i <= hi; i++) begin
            if (gapped && (i % 3 == 2)) begin
                i_en = 1'b0;
                i_d  = 1'($urandom_range(0, 1));
                tick();
            end
            if (i == hi) check("valid_low_before_last", {31'd0, o_valid}, 32'd0);
            i_en = 1'b1;
            i_d  = w[i];
            tick();
        end
        i_en = 1'b0;
        i_d  = 1'b0;
    endtask

    task automatic check_hold();
        check("valid_after_last", {31'd0, o_valid}, 32'd1);
        check("busy_in_hold", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic accept();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("idle_after_accept", {30'd0, o_state}, 32'd0);
    endtask

    // scoreboard monitor: compares each word as it is handed over
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", o_q, 32'hxxxx_xxxx);
            end else begin
                check("word", o_q, exp_q.pop_front());
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_en = 1'b0; i_d = 1'b0;
        i_len = 2'd2; i_signed = 1'b0; i_ready = 1'b0;
        #12;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_q", o_q, 32'd0);
        check("rst_state", {30'd0, o_state}, 32'd0);
        i_rst = 1'b0;
        tick();

        // IDLE ignores i_en/i_d
        i_en = 1'b1; i_d = 1'b1;
        tick();
        check("idle_ignores_en", {30'd0, o_state}, 32'd0);
        i_en = 1'b0; i_d = 1'b0;

        // full word
        exp_q.push_back(32'hDEAD_BEEF);
        start_word(2'd2, 1'b0);
        check("q_cleared_in_collect", o_q, 32'd0);
        send_bits(32'hDEAD_BEEF, 0, 31, 1'b0);
        check_hold();
        accept();
        check("q_held_in_idle", o_q, 32'hDEAD_BEEF);

        // gapped word, then backpressure with ignored starts
        exp_q.push_back(32'hDEAD_BEEF);
        start_word(2'd2, 1'b0);
        send_bits(32'hDEAD_BEEF, 0, 31, 1'b1);
        check_hold();
        for (int k = 0; k < 5; k++) begin
            i_start = k[0];
            i_en = 1'b1;
            i_d = 1'($urandom_range(0, 1));
            tick();
            check("stall_q_stable", o_q, 32'hDEAD_BEEF);
            check("stall_valid", {31'd0, o_valid}, 32'd1);
        end
        i_en = 1'b0;

        // back-to-back: accept and restart in one cycle
        i_ready = 1'b1; i_start = 1'b1;
        tick();
        i_ready = 1'b0; i_start = 1'b0;
        check("b2b_busy", {31'd0, o_busy}, 32'd1);
        check("b2b_valid", {31'd0, o_valid}, 32'd0);
        check("b2b_q_cleared", o_q, 32'd0);
        exp_q.push_back(32'h1234_5678);
        send_bits(32'h1234_5678, 0, 31, 1'b0);
        check_hold();
        accept();

        // start pulse mid-collection is ignored
        exp_q.push_back(32'hA5C3_0F96);
        start_word(2'd2, 1'b0);
        send_bits(32'hA5C3_0F96, 0, 16, 1'b0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("mid_start_busy", {31'd0, o_busy}, 32'd1);
        send_bits(32'hA5C3_0F96, 17, 31, 1'b0);
        check_hold();
        accept();

`ifdef SER_DESER_SEXT_EN
        exp_q.push_back(32'hFFFF_FF80);
        start_word(2'd0, 1'b1);
        i_len = 2'd2; i_signed = 1'b0;
        send_bits(32'h0000_0080, 0, 7, 1'b0);
        check_hold();
        accept();

        exp_q.push_back(32'h0000_8001);
        start_word(2'd1, 1'b0);
        i_len = 2'd2;
        send_bits(32'h0000_8001, 0, 15, 1'b0);
        check_hold();
        accept();
`endif

        // asynchronous reset mid-collection
        start_word(2'd2, 1'b0);
        send_bits(32'hFFFF_FFFF, 0, 9, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, o_busy}, 32'd0);
        check("async_rst_q", o_q, 32'd0);
        check("async_rst_state", {30'd0, o_state}, 32'd0);
        #10;
        i_rst = 1'b0;
        tick();
        check("post_rst_state", {30'd0, o_state}, 32'd0);
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ser_deser.md
Name: ser_deser

Overview:
- Bit-serial to parallel collector for the bit-serial datapath.
- Consumes an LSB-first serial stream, such as a shifter or ALU result, one qualified bit per cycle.
- Assembles the stream into a WIDTH-bit word and presents it to a parallel consumer (register file write port, bus write data) with a valid/ready handshake.
- It is the receiving end of the serial result stream that bit-serial units produce.

Parameters:
- WIDTH, 32, word width in bits. Must be a power of two and at least 8. Must equal 32 when SER_DESER_SEXT_EN is defined.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  begin a new collection; honoured only in IDLE, or in HOLD during the cycle the word is accepted
- i_en  input  1  qualifies i_d in COLLECT; one bit consumed per cycle with i_en=1
- i_d  input  1  serial data, LSB first
- i_len  input  2  transfer length (0=byte, 1=half, 2/3=word); used only with SER_DESER_SEXT_EN
- i_signed  input  1  sign-extend short transfers; used only with SER_DESER_SEXT_EN
- o_busy  output  1  high in COLLECT
- o_valid  output  1  high in HOLD
- i_ready  input  1  consumer accepts o_q when o_valid=1
- o_q  output  WIDTH  assembled word

Behaviour:
- States: IDLE, COLLECT, HOLD (2-bit encoding).
- Bit counter cnt: log2(WIDTH) bits. Shift register sr: WIDTH bits.
- Reset (asynchronous, any state, mid-collection included):
  - state=IDLE, cnt=0, sr=0.
  - o_busy=0, o_valid=0, o_q=0.
- IDLE:
  - i_start=1 -> COLLECT next cycle; cnt<=0, sr<=0.
  - i_en and i_d are ignored in IDLE, including the i_start cycle. The first bit is taken the cycle after i_start.
- COLLECT:
  - On each cycle with i_en=1: sr <= {i_d, sr[WIDTH-1:1]}, cnt <= cnt+1.
  - A cycle with i_en=0 holds sr and cnt. Gaps of any length are legal.
  - Last bit: i_en=1 with cnt==N-1, where N=WIDTH, or as set by i_len under the feature -> HOLD next cycle.
  - Latency: o_valid rises exactly 1 cycle after the last qualified bit.
  - i_start in COLLECT is ignored; the collection is not restarted.
- HOLD:
  - o_q is stable. i_en and i_d are ignored.
  - i_ready=1 -> transfer completes.
    - If i_start=1 in the same cycle -> COLLECT (back-to-back: cnt<=0, sr<=0, no IDLE bubble).
    - Otherwise -> IDLE.
  - i_start=1 with i_ready=0 is ignored and not queued.
- o_q = sr in HOLD.
  - o_q holds its last value in IDLE.
  - o_q is cleared on entering COLLECT, so a partial word is never visible as valid.
- cnt wrap: cnt==WIDTH-1 plus a bit gives cnt=0 naturally. The state leaves COLLECT in that same cycle, so no extra bits are ever absorbed.
- o_busy and o_valid are registered-state decodes, never both high.

Optional Feature:
- Macro: SER_DESER_SEXT_EN.
- Defined:
  - i_len and i_signed are latched on the i_start cycle that is honoured.
  - N = 8, 16 or 32 per latched i_len.
  - Bits shift into sr[N-1], i.e. the shift register is effectively N bits wide.
  - In HOLD, o_q[N-1:0] holds the received bits.
  - o_q[31:N] = latched i_signed ? o_q[N-1] : 0.
  - Byte, half and word take 8, 16 and 32 qualified bits respectively.
- Undefined:
  - i_len and i_signed are ignored. No latch registers are built.
  - N = WIDTH always.

Test Plan:
- Reset mid-collection:
  - i_start, then feed 10 bits, then assert i_rst asynchronously between clock edges.
  - -> o_busy and o_q go to 0 immediately without waiting for a clock edge. After release, state is IDLE.
- Full word:
  - WIDTH=32, i_start, then 32 cycles of i_en=1 carrying 0xDEADBEEF LSB first.
  - -> o_valid=1 exactly 1 cycle after bit 31, o_q=0xDEADBEEF, o_busy=0.
- Gapped stream:
  - Same word with i_en=0 every third cycle and random i_d during the gaps.
  - -> o_q=0xDEADBEEF; the gap bits do not affect the result.
- Backpressure and back-to-back:
  - Hold i_ready=0 for 5 cycles -> o_q stays stable. Toggle i_start during the stall -> ignored.
  - Then assert i_ready=1 with i_start=1 -> o_busy=1 next cycle.
  - A second word 0x12345678 is collected correctly.
- Start ignored mid-collection:
  - Pulse i_start after bit 16.
  - -> the collection continues and completes after 32 bits with the correct word.
- With SER_DESER_SEXT_EN:
  - i_len=0, i_signed=1, bits of 0x80 -> o_q=0xFFFFFF80 after 8 bits.
  - i_len=1, i_signed=0, bits of 0x8001 -> o_q=0x00008001 after 16 bits.
